// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nand4_tester.sv
// Self-test sequencer for a nand4 cell: walks all 16 input vectors, samples ZN
// after a programmable settle time and records mismatch count and first failing vector.
module gf180mcu_fd_sc_mcu7t5v0__nand4_tester #(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       START,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       A4,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERRCNT,
  output logic [3:0] FAILVEC
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_e     state_q;
  logic [3:0] vec_q;
  logic [3:0] hc_q;
  logic [3:0] a_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] errcnt_q;
  logic [3:0] failvec_q;

  logic       exp_s;
  logic       mismatch_s;
  logic [4:0] errcnt_d;
  logic [3:0] failvec_d;

  // Compare ZN against the ideal nand4; an X/Z on ZN falls into the else branch and counts as a mismatch.
  always_comb begin
    exp_s      = ~&vec_q;
    mismatch_s = 1'b1;
    if (ZN == exp_s) begin
      mismatch_s = 1'b0;
    end else begin
      mismatch_s = 1'b1;
    end
    errcnt_d  = errcnt_q + {4'd0, mismatch_s};
    failvec_d = failvec_q;
    if (mismatch_s && (errcnt_q == 5'd0)) begin
      failvec_d = vec_q;
    end else begin
      failvec_d = failvec_q;
    end
  end

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state_q   <= ST_IDLE;
      vec_q     <= 4'd0;
      hc_q      <= 4'd0;
      a_q       <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      errcnt_q  <= 5'd0;
      failvec_q <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state_q   <= ST_APPLY;
            vec_q     <= 4'd0;
            hc_q      <= 4'd0;
            a_q       <= 4'd0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            errcnt_q  <= 5'd0;
            failvec_q <= 4'd0;
          end else begin
            state_q <= state_q;
          end
        end
        ST_APPLY: begin
          if (hc_q != SETTLE_C) begin
            hc_q <= hc_q + 4'd1;
          end else begin
            errcnt_q  <= errcnt_d;
            failvec_q <= failvec_d;
            if (vec_q == 4'd15) begin
              // A pins drop to zero on the same edge DONE rises.
              state_q <= ST_DONE;
              a_q     <= 4'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (errcnt_d == 5'd0);
            end else begin
              vec_q <= vec_q + 4'd1;
              a_q   <= vec_q + 4'd1;
              hc_q  <= 4'd0;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          vec_q     <= 4'd0;
          hc_q      <= 4'd0;
          a_q       <= 4'd0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          pass_q    <= 1'b0;
          errcnt_q  <= 5'd0;
          failvec_q <= 4'd0;
        end
      endcase
    end
  end

  assign A1      = a_q[0];
  assign A2      = a_q[1];
  assign A3      = a_q[2];
  assign A4      = a_q[3];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERRCNT  = errcnt_q;
  assign FAILVEC = failvec_q;

endmodule
